// File: rtl/powlib_ipmaxi.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : powlib_ipmaxi
// Purpose  : AXI4-Lite master bridge. Takes single-beat powlib requests from
//            the crossbar and issues them as AXI4-Lite writes or reads; read
//            data returns to the requester as a powlib write to the return
//            address carried in the request. One transaction in flight.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`ifndef POWLIB_OPW
`define POWLIB_OPW 2
`endif

module powlib_ipmaxi #(
  parameter       ID       = "IPMAXI",
  parameter int   EDBG     = 0,
  parameter int   B_BPD    = 4,
  parameter int   B_AW     = 32,
  parameter int   OPW      = `POWLIB_OPW,
  parameter int   OP_WRITE = 0,
  parameter int   OP_READ  = 1,
  parameter int   B_DW     = 8*B_BPD,
  parameter int   B_BEW    = B_BPD,
  parameter int   B_WW     = B_DW+B_BEW+OPW
) (
  input  logic              clk,
  input  logic              rst,
  // Request side (from crossbar)
  input  logic [B_AW-1:0]   wraddr,
  input  logic [B_WW-1:0]   wrdata,
  input  logic              wrvld,
  output logic              wrrdy,
  // Response side (to crossbar)
  output logic [B_AW-1:0]   rdaddr,
  output logic [B_WW-1:0]   rddata,
  output logic              rdvld,
  input  logic              rdrdy,
  // AXI4-Lite write address
  output logic [B_AW-1:0]   awaddr,
  output logic              awvalid,
  input  logic              awready,
  // AXI4-Lite write data
  output logic [B_DW-1:0]   wdata,
  output logic [B_BEW-1:0]  wstrb,
  output logic              wvalid,
  input  logic              wready,
  // AXI4-Lite write response
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready,
  // AXI4-Lite read address
  output logic [B_AW-1:0]   araddr,
  output logic              arvalid,
  input  logic              arready,
  // AXI4-Lite read data
  input  logic [B_DW-1:0]   rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  // Error counter
  output logic [7:0]        errcnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_REQ  = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_DATA = 3'd4,
    S_RSP     = 3'd5
  } state_t;

  localparam logic [OPW-1:0]   c_op_write = OPW'(OP_WRITE);
  localparam logic [OPW-1:0]   c_op_read  = OPW'(OP_READ);
  localparam logic [B_BEW-1:0] c_be_all   = {B_BEW{1'b1}};

  // Debug prints are simulation-only and have no hardware; only sanity-check
  // the EDBG parameter at elaboration.
  if (EDBG != 0 && EDBG != 1) begin : g_edbg_chk
    $error("powlib_ipmaxi: EDBG must be 0 or 1");
  end

  state_t             r_state;
  logic               r_wrrdy;
  logic [B_AW-1:0]    r_addr;
  logic [B_DW-1:0]    r_wdata;
  logic [B_BEW-1:0]   r_wstrb;
  logic [B_AW-1:0]    r_rdaddr;
  logic [B_WW-1:0]    r_rddata;
  logic               r_rdvld;
  logic               r_awvalid;
  logic               r_wvalid;
  logic               r_bready;
  logic               r_arvalid;
  logic               r_rready;
  logic [7:0]         r_errcnt;

  // Unpack the request word: {op, be, data}.
  logic [B_DW-1:0]    w_req_data;
  logic [B_BEW-1:0]   w_req_be;
  logic [OPW-1:0]     w_req_op;
  logic               w_aw_done;
  logic               w_w_done;
  logic [7:0]         w_errcnt_inc;

  assign w_req_data   = wrdata[B_DW-1:0];
  assign w_req_be     = wrdata[B_DW +: B_BEW];
  assign w_req_op     = wrdata[B_WW-1 -: OPW];
  // A channel counts as done once its valid has been accepted (now or earlier).
  assign w_aw_done    = !r_awvalid || awready;
  assign w_w_done     = !r_wvalid  || wready;
  assign w_errcnt_inc = (r_errcnt == 8'hFF) ? r_errcnt : r_errcnt + 8'd1;

  // Transaction sequencer; every output is a register driven from here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_wrrdy   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_rdaddr  <= '0;
      r_rddata  <= '0;
      r_rdvld   <= 1'b0;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_errcnt  <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!r_wrrdy) begin
            // Guarantees one idle cycle after reset or a finished transaction.
            r_wrrdy <= 1'b1;
          end else if (wrvld) begin
            r_addr  <= wraddr;
            r_wdata <= w_req_data;
            r_wstrb <= w_req_be;
            if (w_req_op == c_op_write) begin
              r_state   <= S_WR_REQ;
              r_wrrdy   <= 1'b0;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
            end else if (w_req_op == c_op_read) begin
              r_state   <= S_RD_REQ;
              r_wrrdy   <= 1'b0;
              r_arvalid <= 1'b1;
              r_rdaddr  <= B_AW'(w_req_data);
            end else begin
              // Unknown op: swallow it and stay ready.
              r_errcnt <= w_errcnt_inc;
            end
          end
        end
        S_WR_REQ: begin
          if (r_awvalid && awready) r_awvalid <= 1'b0;
          if (r_wvalid  && wready)  r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_state  <= S_WR_RESP;
            r_bready <= 1'b1;
          end
        end
        S_WR_RESP: begin
          if (bvalid) begin
            r_state  <= S_IDLE;
            r_bready <= 1'b0;
            if (bresp != 2'b00) r_errcnt <= w_errcnt_inc;
          end
        end
        S_RD_REQ: begin
          if (arready) begin
            r_state   <= S_RD_DATA;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
          end
        end
        S_RD_DATA: begin
          if (rvalid) begin
            // Error responses still forward their data to the requester.
            r_state  <= S_RSP;
            r_rready <= 1'b0;
            r_rdvld  <= 1'b1;
            r_rddata <= {c_op_write, c_be_all, rdata};
            if (rresp != 2'b00) r_errcnt <= w_errcnt_inc;
          end
        end
        S_RSP: begin
          if (rdrdy) begin
            r_state <= S_IDLE;
            r_rdvld <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign wrrdy   = r_wrrdy;
  assign rdaddr  = r_rdaddr;
  assign rddata  = r_rddata;
  assign rdvld   = r_rdvld;
  assign awaddr  = r_addr;
  assign awvalid = r_awvalid;
  assign wdata   = r_wdata;
  assign wstrb   = r_wstrb;
  assign wvalid  = r_wvalid;
  assign bready  = r_bready;
  assign araddr  = r_addr;
  assign arvalid = r_arvalid;
  assign rready  = r_rready;
  assign errcnt  = r_errcnt;

endmodule

`default_nettype wire

// File: tb/tb_powlib_ipmaxi.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_powlib_ipmaxi
// Purpose  : Directed self-checking bench for powlib_ipmaxi. The AXI slave is
//            played cycle by cycle from the test tasks.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_powlib_ipmaxi;

  localparam int B_AW = 32;
  localparam int B_DW = 32;
  localparam int B_BEW = 4;
  localparam int OPW = 2;
  localparam int B_WW = B_DW + B_BEW + OPW;
  localparam logic [OPW-1:0] OPC_WR = 2'd0;
  localparam logic [OPW-1:0] OPC_RD = 2'd1;

  logic              clk = 1'b0;
  logic              rst;
  logic [B_AW-1:0]   wraddr;
  logic [B_WW-1:0]   wrdata;
  logic              wrvld;
  logic              wrrdy;
  logic [B_AW-1:0]   rdaddr;
  logic [B_WW-1:0]   rddata;
  logic              rdvld;
  logic              rdrdy;
  logic [B_AW-1:0]   awaddr;
  logic              awvalid;
  logic              awready;
  logic [B_DW-1:0]   wdata;
  logic [B_BEW-1:0]  wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [B_AW-1:0]   araddr;
  logic              arvalid;
  logic              arready;
  logic [B_DW-1:0]   rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  logic [7:0]        errcnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  powlib_ipmaxi dut (
    .clk(clk), .rst(rst),
    .wraddr(wraddr), .wrdata(wrdata), .wrvld(wrvld), .wrrdy(wrrdy),
    .rdaddr(rdaddr), .rddata(rddata), .rdvld(rdvld), .rdrdy(rdrdy),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .errcnt(errcnt)
  );

  // Bounded wait for the bridge to be ready, sampled on the falling edge.
  task automatic wait_rdy(input string nm);
    int i;
    for (i = 0; i < 20; i++) begin
      if (wrrdy === 1'b1) break;
      @(negedge clk);
    end
    n_chk++;
    if (wrrdy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s wait_wrrdy: got %b want 1 (timeout)", nm, wrrdy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; wraddr = '0; wrdata = '0; wrvld = 1'b0; rdrdy = 1'b0;
    awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b0;
    arready = 1'b0; rdata = '0; rresp = 2'b00; rvalid = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++; if (wrrdy !== 1'b0)   begin n_fail++; $display("FAIL reset wrrdy: got %b want 0", wrrdy); end
    n_chk++; if ({awvalid, wvalid, arvalid, bready, rready, rdvld} !== 6'b0)
      begin n_fail++; $display("FAIL reset valids: got %b want 000000", {awvalid, wvalid, arvalid, bready, rready, rdvld}); end
    n_chk++; if (errcnt !== 8'd0)  begin n_fail++; $display("FAIL reset errcnt: got %0h want 0", errcnt); end
    n_chk++; if ({awaddr, araddr, wdata, wstrb, rdaddr, rddata} !== '0)
      begin n_fail++; $display("FAIL reset data_addr: got nonzero want 0"); end
    rst = 1'b0;
    @(negedge clk);
    n_chk++; if (wrrdy !== 1'b1)   begin n_fail++; $display("FAIL reset wrrdy_rise: got %b want 1", wrrdy); end
  endtask

  // Write with AW ready after awd cycles and W ready after wd cycles.
  task automatic do_write(input string nm, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] be, input int awd, input int wd,
                          input logic [1:0] resp, input logic [7:0] exp_err);
    int aw_cnt, w_cnt, kb, k;
    aw_cnt = 0; w_cnt = 0; kb = 0;
    wait_rdy(nm);
    wraddr = addr; wrdata = {OPC_WR, be, data}; wrvld = 1'b1;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    @(negedge clk);
    wrvld = 1'b0; wrdata = '0; wraddr = '0;
    n_chk++; if ({awvalid, wvalid} !== 2'b11) begin n_fail++; $display("FAIL %s aw_w_valid: got %b want 11", nm, {awvalid, wvalid}); end
    n_chk++; if (awaddr !== addr) begin n_fail++; $display("FAIL %s awaddr: got %h want %h", nm, awaddr, addr); end
    n_chk++; if (wdata !== data)  begin n_fail++; $display("FAIL %s wdata: got %h want %h", nm, wdata, data); end
    n_chk++; if (wstrb !== be)    begin n_fail++; $display("FAIL %s wstrb: got %h want %h", nm, wstrb, be); end
    n_chk++; if (wrrdy !== 1'b0)  begin n_fail++; $display("FAIL %s wrrdy_busy: got %b want 0", nm, wrrdy); end
    for (k = 1; k < 30; k++) begin
      if (bready === 1'b1) begin kb = k; break; end
      if (awvalid === 1'b1) aw_cnt++;
      if (wvalid === 1'b1) w_cnt++;
      awready = (k >= awd + 1);
      wready  = (k >= wd + 1);
      @(negedge clk);
    end
    awready = 1'b0; wready = 1'b0;
    n_chk++; if (kb !== ((awd > wd ? awd : wd) + 2))
      begin n_fail++; $display("FAIL %s bready_cycle: got %0d want %0d", nm, kb, (awd > wd ? awd : wd) + 2); end
    n_chk++; if (aw_cnt !== awd + 1) begin n_fail++; $display("FAIL %s awvalid_cycles: got %0d want %0d", nm, aw_cnt, awd + 1); end
    n_chk++; if (w_cnt !== wd + 1)   begin n_fail++; $display("FAIL %s wvalid_cycles: got %0d want %0d", nm, w_cnt, wd + 1); end
    bvalid = 1'b1; bresp = resp;
    @(negedge clk);
    bvalid = 1'b0; bresp = 2'b00;
    n_chk++; if (bready !== 1'b0) begin n_fail++; $display("FAIL %s bready_drop: got %b want 0", nm, bready); end
    n_chk++; if (wrrdy !== 1'b0)  begin n_fail++; $display("FAIL %s wrrdy_gap: got %b want 0", nm, wrrdy); end
    @(negedge clk);
    n_chk++; if (wrrdy !== 1'b1)  begin n_fail++; $display("FAIL %s wrrdy_back: got %b want 1", nm, wrrdy); end
    n_chk++; if (errcnt !== exp_err) begin n_fail++; $display("FAIL %s errcnt: got %0h want %0h", nm, errcnt, exp_err); end
  endtask

  // Read from a zero-wait slave; rdrdy held off for hold cycles.
  task automatic do_read(input string nm, input logic [31:0] addr, input logic [31:0] ret,
                         input logic [31:0] data, input logic [1:0] resp, input int hold,
                         input logic [7:0] exp_err);
    logic [B_WW-1:0] exp_rd;
    exp_rd = {OPC_WR, 4'hF, data};
    wait_rdy(nm);
    wraddr = addr; wrdata = {OPC_RD, 4'h0, ret}; wrvld = 1'b1; arready = 1'b0;
    @(negedge clk);
    wrvld = 1'b0; wrdata = '0; wraddr = '0;
    n_chk++; if (arvalid !== 1'b1) begin n_fail++; $display("FAIL %s arvalid: got %b want 1", nm, arvalid); end
    n_chk++; if (araddr !== addr)  begin n_fail++; $display("FAIL %s araddr: got %h want %h", nm, araddr, addr); end
    n_chk++; if ({awvalid, wvalid, rready} !== 3'b000) begin n_fail++; $display("FAIL %s idle_chans: got %b want 000", nm, {awvalid, wvalid, rready}); end
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    n_chk++; if ({arvalid, rready} !== 2'b01) begin n_fail++; $display("FAIL %s ar_done: got %b want 01", nm, {arvalid, rready}); end
    rvalid = 1'b1; rdata = data; rresp = resp;
    @(negedge clk);
    rvalid = 1'b0; rdata = 32'hA5A5_5A5A; rresp = 2'b00;
    n_chk++; if ({rdvld, rready} !== 2'b10) begin n_fail++; $display("FAIL %s rdvld: got %b want 10", nm, {rdvld, rready}); end
    n_chk++; if (rdaddr !== ret)    begin n_fail++; $display("FAIL %s rdaddr: got %h want %h", nm, rdaddr, ret); end
    n_chk++; if (rddata !== exp_rd) begin n_fail++; $display("FAIL %s rddata: got %h want %h", nm, rddata, exp_rd); end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      n_chk++;
      if ({rdvld, rdaddr, rddata} !== {1'b1, ret, exp_rd})
        begin n_fail++; $display("FAIL %s hold%0d: got %b/%h/%h want 1/%h/%h", nm, i, rdvld, rdaddr, rddata, ret, exp_rd); end
    end
    rdrdy = 1'b1;
    @(negedge clk);
    rdrdy = 1'b0;
    n_chk++; if ({rdvld, wrrdy} !== 2'b00) begin n_fail++; $display("FAIL %s rsp_done: got %b want 00", nm, {rdvld, wrrdy}); end
    n_chk++; if (errcnt !== exp_err) begin n_fail++; $display("FAIL %s errcnt: got %0h want %0h", nm, errcnt, exp_err); end
    @(negedge clk);
    n_chk++; if (wrrdy !== 1'b1) begin n_fail++; $display("FAIL %s wrrdy_back: got %b want 1", nm, wrrdy); end
  endtask

  task automatic test_write_basic();
    do_write("wr_basic", 32'h5002_0004, 32'hDEAD_BEEF, 4'hF, 0, 0, 2'b00, 8'd0);
  endtask

  task automatic test_read_hold();
    do_read("rd_hold", 32'h5002_0004, 32'h5000_0010, 32'h1234_5678, 2'b00, 3, 8'd0);
  endtask

  task automatic test_write_skew();
    do_write("wr_aw_late", 32'h5002_0009, 32'h0BAD_F00D, 4'h0, 3, 0, 2'b00, 8'd0);
    do_write("wr_w_late",  32'h5002_0013, 32'hCAFE_0001, 4'h5, 0, 3, 2'b00, 8'd0);
  endtask

  task automatic test_errors();
    do_write("wr_slverr", 32'h5002_0020, 32'h1111_2222, 4'h3, 0, 0, 2'b10, 8'd1);
    do_read("rd_decerr", 32'h5002_0024, 32'h5000_0044, 32'h8765_4321, 2'b11, 0, 8'd2);
  endtask

  task automatic test_bad_op();
    logic [7:0] exp_e;
    wait_rdy("bad_op");
    wraddr = 32'h5002_0030; wrdata = {2'd3, 4'hF, 32'h0}; wrvld = 1'b1;
    @(negedge clk);
    wrvld = 1'b0;
    n_chk++; if (wrrdy !== 1'b1) begin n_fail++; $display("FAIL bad_op wrrdy: got %b want 1", wrrdy); end
    n_chk++; if ({awvalid, wvalid, arvalid} !== 3'b000) begin n_fail++; $display("FAIL bad_op axi: got %b want 000", {awvalid, wvalid, arvalid}); end
    n_chk++; if (errcnt !== 8'd3) begin n_fail++; $display("FAIL bad_op errcnt: got %0h want 3", errcnt); end
    wrvld = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      exp_e = (3 + i > 255) ? 8'hFF : 8'(3 + i);
      n_chk++; if (errcnt !== exp_e) begin n_fail++; $display("FAIL bad_op_sat%0d errcnt: got %0h want %0h", i, errcnt, exp_e); end
    end
    wrvld = 1'b0; wrdata = '0;
    n_chk++; if ({awvalid, wvalid, arvalid} !== 3'b000) begin n_fail++; $display("FAIL bad_op_sat axi: got %b want 000", {awvalid, wvalid, arvalid}); end
  endtask

  task automatic test_reset_mid();
    wait_rdy("rst_mid");
    wraddr = 32'h5002_0040; wrdata = {OPC_RD, 4'h0, 32'h5000_0050}; wrvld = 1'b1;
    @(negedge clk);
    wrvld = 1'b0;
    n_chk++; if (arvalid !== 1'b1) begin n_fail++; $display("FAIL rst_mid arvalid_pre: got %b want 1", arvalid); end
    rst = 1'b1;
    @(negedge clk);
    n_chk++; if ({arvalid, rready, rdvld, wrrdy} !== 4'b0000)
      begin n_fail++; $display("FAIL rst_mid outs: got %b want 0000", {arvalid, rready, rdvld, wrrdy}); end
    n_chk++; if (errcnt !== 8'd0) begin n_fail++; $display("FAIL rst_mid errcnt: got %0h want 0", errcnt); end
    rst = 1'b0;
    do_write("wr_after_rst", 32'h5002_0044, 32'h600D_600D, 4'hC, 0, 0, 2'b00, 8'd0);
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_hold();
    test_write_skew();
    test_errors();
    test_bad_op();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
